hex_message_sequencer: RTL

HEX_MESSAGE_SEQUENCER -- requirements
Module: hex_message_sequencer

---
 rtl/hex_message_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hex_message_sequencer.sv
// Four-digit seven-segment message sequencer: shows a BCD score while idle and
// flashes a LOSE/GOOD banner on request, then holds it until cleared.
module hex_message_sequencer #(
    parameter int TICK_DIV    = 25000000,
    parameter int FLASH_COUNT = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lose_req,
    input  logic        win_req,
    input  logic        clear,
    input  logic        show_score,
    input  logic [15:0] score_bcd,
    output logic [7:0]  HEX5VALUE,
    output logic [7:0]  HEX4VALUE,
    output logic [7:0]  HEX3VALUE,
    output logic [7:0]  HEX2VALUE,
    output logic        busy,
    output logic        anim_done
);

    localparam int              TW         = $clog2(TICK_DIV);
    localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [3:0]      FLASH_LAST = 4'(FLASH_COUNT);
    localparam logic [31:0]     LOSE_PAT   = 32'hC7C0_9286;
    localparam logic [31:0]     WIN_PAT    = 32'hC2C0_C0A1;
    localparam logic [31:0]     BLANK_PAT  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t          state_r;
    logic            msg_sel_r;
    logic [TW-1:0]   tick_r;
    logic [3:0]      on_cnt_r;
    logic [31:0]     hex_r;
    logic            busy_r;
    logic            anim_done_r;

    logic            accept_lose_s;
    logic            accept_win_s;
    logic            tick_end_s;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] seg;
        case (d)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hBF;
        endcase
        return seg;
    endfunction

    function automatic logic [31:0] score_display(input logic show, input logic [15:0] bcd);
        logic [31:0] disp;
        if (show) begin
            disp = {seg_decode(bcd[15:12]), seg_decode(bcd[11:8]),
                    seg_decode(bcd[7:4]),   seg_decode(bcd[3:0])};
        end else begin
            disp = BLANK_PAT;
        end
        return disp;
    endfunction

    function automatic logic [31:0] pattern(input logic sel);
        return sel ? LOSE_PAT : WIN_PAT;
    endfunction

    // Request acceptance: LOSE may preempt a WIN run, WIN only starts from idle.
    always_comb begin
        accept_lose_s = 1'b0;
        accept_win_s  = 1'b0;
        tick_end_s    = (tick_r == TICK_LAST);
        if (lose_req && ((state_r == IDLE) || !msg_sel_r)) begin
            accept_lose_s = 1'b1;
        end else if (win_req && (state_r == IDLE)) begin
            accept_win_s = 1'b1;
        end else begin
            accept_lose_s = 1'b0;
            accept_win_s  = 1'b0;
        end
    end

    // Sequencer FSM; display is computed for the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            msg_sel_r   <= 1'b0;
            tick_r      <= {TW{1'b0}};
            on_cnt_r    <= 4'd0;
            hex_r       <= BLANK_PAT;
            busy_r      <= 1'b0;
            anim_done_r <= 1'b0;
        end else if (accept_lose_s || accept_win_s) begin
            state_r     <= FLASH_ON;
            msg_sel_r   <= accept_lose_s;
            tick_r      <= {TW{1'b0}};
            on_cnt_r    <= 4'd1;
            hex_r       <= pattern(accept_lose_s);
            busy_r      <= 1'b1;
            anim_done_r <= 1'b0;
        end else begin
            anim_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    hex_r  <= score_display(show_score, score_bcd);
                    busy_r <= 1'b0;
                end
                FLASH_ON: begin
                    if (tick_end_s) begin
                        state_r <= FLASH_OFF;
                        tick_r  <= {TW{1'b0}};
                        hex_r   <= BLANK_PAT;
                    end else begin
                        tick_r  <= tick_r + TW'(1);
                    end
                end
                FLASH_OFF: begin
                    if (tick_end_s) begin
                        tick_r <= {TW{1'b0}};
                        hex_r  <= pattern(msg_sel_r);
                        if (on_cnt_r < FLASH_LAST) begin
                            state_r  <= FLASH_ON;
                            on_cnt_r <= on_cnt_r + 4'd1;
                        end else begin
                            state_r     <= HOLD;
                            anim_done_r <= 1'b1;
                        end
                    end else begin
                        tick_r <= tick_r + TW'(1);
                    end
                end
                HOLD: begin
                    if (clear) begin
                        state_r  <= IDLE;
                        on_cnt_r <= 4'd0;
                        busy_r   <= 1'b0;
                        hex_r    <= score_display(show_score, score_bcd);
                    end else begin
                        hex_r    <= pattern(msg_sel_r);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    hex_r   <= BLANK_PAT;
                end
            endcase
        end
    end

    assign HEX5VALUE = hex_r[31:24];
    assign HEX4VALUE = hex_r[23:16];
    assign HEX3VALUE = hex_r[15:8];
    assign HEX2VALUE = hex_r[7:0];
    assign busy      = busy_r;
    assign anim_done = anim_done_r;

endmodule
